// File: rtl/tlb_fill_ctrl.sv
// 8-entry x 44-bit TLB fill controller: IDLE -> SEARCH (victim select) -> WRITE.
// Optional macro TLB_FILL_PRELOAD_EN: reset loads entry i with VPN=i, PFN=i, valid/present/rw=1.
module tlb_fill_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill_valid,
  output logic         fill_ready,
  input  logic [19:0]  fill_vpn,
  input  logic [2:0]   fill_pfn,
  input  logic         fill_present,
  input  logic         fill_rw,
  input  logic         inv_all,
  output logic         fill_done,
  output logic [2:0]   fill_idx,
  output logic [351:0] TLB
);

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_t;

  state_t            r_state, w_next;
  logic [7:0][43:0]  r_tlb;
  logic [19:0]       r_vpn;
  logic [2:0]        r_pfn;
  logic              r_present, r_rw;
  logic [2:0]        r_victim, r_rr_ptr;
  logic              r_use_rr;

  logic              w_hs;
  logic              w_hit, w_free, w_use_rr;
  logic [2:0]        w_hit_idx, w_free_idx, w_victim;

  assign TLB      = r_tlb;
  assign fill_idx = r_victim;

  // Victim select: lowest matching valid entry, else lowest invalid, else round-robin
  always_comb begin
    w_hit      = 1'b0;
    w_free     = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_hit && r_tlb[i][3] && (r_tlb[i][43:24] == r_vpn)) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(i);
      end
      if (!w_free && !r_tlb[i][3]) begin
        w_free     = 1'b1;
        w_free_idx = 3'(i);
      end
    end
    w_use_rr = 1'b0;
    if (w_hit) begin
      w_victim = w_hit_idx;
    end else if (w_free) begin
      w_victim = w_free_idx;
    end else begin
      w_victim = r_rr_ptr;
      w_use_rr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    fill_ready = 1'b0;
    fill_done  = 1'b0;
    w_hs       = 1'b0;
    case (r_state)
      IDLE: begin
        fill_ready = !inv_all;
        w_hs       = fill_valid && !inv_all;
        if (w_hs) w_next = SEARCH;
      end
      SEARCH: w_next = WRITE;
      WRITE: begin
        fill_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (inv_all) begin
      w_next    = IDLE;
      fill_done = 1'b0;
    end
    if (rst) begin
      fill_ready = 1'b0;
      fill_done  = 1'b0;
      w_hs       = 1'b0;
    end
  end

  // rr_ptr advances only on a committed write, so an aborted fill never moves it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
`ifdef TLB_FILL_PRELOAD_EN
        r_tlb[i] <= {20'(i), 17'b0, 3'(i), 3'b111, 1'b0};
`else
        r_tlb[i] <= '0;
`endif
      end
      r_vpn     <= '0;
      r_pfn     <= '0;
      r_present <= 1'b0;
      r_rw      <= 1'b0;
      r_victim  <= '0;
      r_rr_ptr  <= '0;
      r_use_rr  <= 1'b0;
    end else if (inv_all) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_tlb[i][3] <= 1'b0;
      end
    end else begin
      if (w_hs) begin
        r_vpn     <= fill_vpn;
        r_pfn     <= fill_pfn;
        r_present <= fill_present;
        r_rw      <= fill_rw;
      end
      if (r_state == SEARCH) begin
        r_victim <= w_victim;
        r_use_rr <= w_use_rr;
      end
      if (r_state == WRITE) begin
        r_tlb[r_victim] <= {r_vpn, 17'b0, r_pfn, 1'b1, r_present, r_rw, 1'b0};
        if (r_use_rr) r_rr_ptr <= r_rr_ptr + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Self-checking bench for tlb_fill_ctrl: directed steps plus randomized fills/invalidates
// checked against a field-level TLB model.
module tb_tlb_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst, fill_valid, fill_present, fill_rw, inv_all;
  logic [19:0]  fill_vpn;
  logic [2:0]   fill_pfn;
  logic         fill_ready, fill_done;
  logic [2:0]   fill_idx;
  logic [351:0] TLB;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int vpn;
    int pfn;
    bit v;
    bit p;
    bit w;
  } ent_t;

  ent_t m_ent [8];
  int   m_rr;

  tlb_fill_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_vpn     (fill_vpn),
    .fill_pfn     (fill_pfn),
    .fill_present (fill_present),
    .fill_rw      (fill_rw),
    .inv_all      (inv_all),
    .fill_done    (fill_done),
    .fill_idx     (fill_idx),
    .TLB          (TLB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [351:0] m_pack();
    logic [351:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      t[44*i +: 44] = {20'(m_ent[i].vpn), 17'b0, 3'(m_ent[i].pfn),
                       m_ent[i].v, m_ent[i].p, m_ent[i].w, 1'b0};
    end
    return t;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
`ifdef TLB_FILL_PRELOAD_EN
      m_ent[i] = '{vpn: i, pfn: i, v: 1'b1, p: 1'b1, w: 1'b1};
`else
      m_ent[i] = '{vpn: 0, pfn: 0, v: 1'b0, p: 1'b0, w: 1'b0};
`endif
    end
    m_rr = 0;
  endfunction

  function automatic void m_inv();
    for (int i = 0; i < 8; i++) m_ent[i].v = 1'b0;
  endfunction

  function automatic int m_pick(input int vpn, output bit use_rr);
    use_rr = 1'b0;
    for (int i = 0; i < 8; i++) if (m_ent[i].v && m_ent[i].vpn == vpn) return i;
    for (int i = 0; i < 8; i++) if (!m_ent[i].v) return i;
    use_rr = 1'b1;
    return m_rr;
  endfunction

  task automatic do_reset();
    rst = 1'b1; fill_valid = 1'b0; inv_all = 1'b0;
    #1;
    chk("ready_in_rst", 352'(fill_ready), 352'(0));
    tick();
    tick();
    m_reset();
    chk("rst_done", 352'(fill_done), 352'(0));
    chk("rst_idx", 352'(fill_idx), 352'(0));
    chk("rst_tlb", TLB, m_pack());
    chk("ready_held_rst", 352'(fill_ready), 352'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 352'(fill_ready), 352'(1));
  endtask

  // abort: 0 none, 1 inv_all in SEARCH, 2 inv_all in WRITE, 3 rst in SEARCH
  task automatic do_fill(input int vpn, input int pfn, input bit pres, input bit rw,
                         input int abort, output int got_idx);
    int e_idx;
    bit use_rr;
    got_idx = -1;
    fill_valid = 1'b1; fill_vpn = 20'(vpn); fill_pfn = 3'(pfn);
    fill_present = pres; fill_rw = rw;
    #1;
    chk("ready_idle", 352'(fill_ready), 352'(1));
    tick();
    fill_valid = 1'b0;
    fill_vpn = 20'($urandom); fill_pfn = 3'($urandom);
    fill_present = 1'($urandom); fill_rw = 1'($urandom);
    e_idx = m_pick(vpn, use_rr);
    if (abort == 1 || abort == 3) begin
      if (abort == 1) inv_all = 1'b1; else rst = 1'b1;
      #1;
      chk("abort_search_done", 352'(fill_done), 352'(0));
      tick();
      if (abort == 1) m_inv(); else m_reset();
      inv_all = 1'b0; rst = 1'b0;
      #1;
      chk("abort_search_tlb", TLB, m_pack());
      chk("abort_search_ready", 352'(fill_ready), 352'(1));
      return;
    end
    #1;
    chk("search_done", 352'(fill_done), 352'(0));
    fill_valid = 1'b1;
    #1;
    chk("search_ready", 352'(fill_ready), 352'(0));
    fill_valid = 1'b0;
    tick();
    if (abort == 2) begin
      inv_all = 1'b1;
      #1;
      chk("abort_write_done", 352'(fill_done), 352'(0));
      tick();
      m_inv();
      inv_all = 1'b0;
      #1;
      chk("abort_write_tlb", TLB, m_pack());
      chk("abort_write_done2", 352'(fill_done), 352'(0));
      return;
    end
    #1;
    chk("write_done", 352'(fill_done), 352'(1));
    chk("write_idx", 352'(fill_idx), 352'(e_idx));
    chk("write_ready", 352'(fill_ready), 352'(0));
    got_idx = e_idx;
    tick();
    m_ent[e_idx] = '{vpn: vpn, pfn: pfn, v: 1'b1, p: pres, w: rw};
    if (use_rr) m_rr = (m_rr + 1) % 8;
    #1;
    chk("post_tlb", TLB, m_pack());
    chk("post_done", 352'(fill_done), 352'(0));
  endtask

  initial begin
    int idx;
    int vp;
    rst = 1'b1; fill_valid = 1'b0; inv_all = 1'b0;
    fill_vpn = '0; fill_pfn = '0; fill_present = 1'b0; fill_rw = 1'b0;
    m_reset();

    do_reset();
`ifdef TLB_FILL_PRELOAD_EN
    chk("preload_e6", 352'(TLB[6*44 +: 44]), 352'(44'h0000600006E));
    do_fill(32'h00006, 1, 1'b1, 1'b1, 0, idx);
    chk("preload_refill_idx", 352'(idx), 352'(6));
`else
    do_fill(32'h12345, 5, 1'b1, 1'b0, 0, idx);
    chk("first_entry", 352'(TLB[43:0]), 352'(44'h1234500005C));
    chk("first_idx", 352'(idx), 352'(0));
`endif

    // Fill all slots, then exercise round-robin and hit-refill
    do_reset();
    for (int i = 0; i < 8; i++) do_fill(32'h10 + i, $urandom_range(0, 7), 1'b1, 1'($urandom), 0, idx);
    do_fill(32'h20, 4, 1'b1, 1'b1, 0, idx);
    do_fill(32'h21, 6, 1'b0, 1'b1, 0, idx);
`ifndef TLB_FILL_PRELOAD_EN
    chk("rr_first", 352'(TLB[43:24]), 352'(20'h00020));
    chk("rr_second_idx", 352'(idx), 352'(1));
`endif
    do_fill(32'h13, 2, 1'b1, 1'b0, 0, idx);
`ifndef TLB_FILL_PRELOAD_EN
    chk("hit_idx", 352'(idx), 352'(3));
`endif
    do_fill(32'h22, 1, 1'b1, 1'b1, 0, idx);

    // inv_all during SEARCH, then next fill lands in the lowest free slot
    do_fill(32'h30, 3, 1'b1, 1'b1, 1, idx);
    do_fill(32'h31, 3, 1'b1, 1'b1, 0, idx);
    chk("after_inv_idx", 352'(idx), 352'(0));

    // fill_valid held while inv_all is high: no handshake
    fill_valid = 1'b1; fill_vpn = 20'h00040; fill_pfn = 3'd7; inv_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("inv_blocks_ready", 352'(fill_ready), 352'(0));
      tick();
      m_inv();
      chk("inv_held_tlb", TLB, m_pack());
    end
    inv_all = 1'b0;
    do_fill(32'h40, 7, 1'b1, 1'b0, 0, idx);

    // Reset in the middle of a fill
    do_fill(32'h50, 2, 1'b1, 1'b1, 3, idx);
    do_fill(32'h51, 2, 1'b1, 1'b1, 0, idx);

    // Randomized traffic over a small VPN pool to mix hits, free slots and round-robin
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        inv_all = 1'b1;
        tick();
        m_inv();
        inv_all = 1'b0;
        #1;
        chk("rand_inv_tlb", TLB, m_pack());
      end else begin
        vp = 32'h60 + $urandom_range(0, 11);
        do_fill(vp, $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                (r == 1) ? 1 : (r == 2) ? 2 : 0, idx);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
